// File: rtl/instr_fetch_buffer_pkg.sv
// ============================================================================
// Module      : instr_fetch_buffer_pkg
// Description : Shared constants, FSM encodings and helpers for the
//               instruction fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_buffer_pkg;

  // Native data/address bus width of the core.
  localparam int c_data_bus_bits = 32;

  // Fetch FSM state encodings.
  typedef logic [1:0] ifb_state_t;
  localparam ifb_state_t c_IFB_S_IDLE  = 2'd0;
  localparam ifb_state_t c_IFB_S_FETCH = 2'd1;
  localparam ifb_state_t c_IFB_S_DRAIN = 2'd2;

  // Saturating increment for 32-bit event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_buffer_fifo.sv
// ============================================================================
// Module      : ifb_fifo
// Description : DEPTH x DATA_W synchronous FIFO with push/pop/clear and
//               count/full/empty status. Clear has priority over push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  // Storage array write (data needs no reset; validity is tracked by count).
  always_ff @(posedge clk) begin
    if (w_do_push && !clear) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_do_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
// ============================================================================
// Module      : instr_fetch_buffer
// Description : Prefetching instruction fetch stage. Issues sequential word
//               requests to a variable-latency memory, buffers responses in
//               a small FIFO and presents them to the core; flushes and
//               refetches on PC discontinuities.
//               Optional feature macro: IFB_STATS_EN (adds stat_* counters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_buffer
  import instr_fetch_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2,
  parameter int ADDR_W    = c_data_bus_bits,
  parameter int DATA_W    = c_data_bus_bits
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              instr_ack,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              pc_misaligned,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data
`ifdef IFB_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushes,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam int                 c_cnt_w     = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w:0]   c_depth_ext = (c_cnt_w + 1)'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_max_outst = c_cnt_w'(MAX_OUTST);

  ifb_state_t         r_state;
  ifb_state_t         w_state_nxt;
  logic [ADDR_W-1:0]  r_fetch_addr;
  logic [ADDR_W-1:0]  r_head_addr;
  logic [c_cnt_w-1:0] r_outst;
  logic [c_cnt_w-1:0] r_discard;
  logic [c_cnt_w-1:0] w_outst_nxt;
  logic [c_cnt_w-1:0] w_discard_nxt;
  logic [c_cnt_w-1:0] w_fifo_count;
  logic [DATA_W-1:0]  w_fifo_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [ADDR_W-1:0]  w_pc_word;
  logic               w_redirect;
  logic               w_accept;
  logic               w_rsp;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic               w_room;

  assign w_pc_word     = {pc_in[ADDR_W-1:2], 2'b00};
  assign pc_misaligned = (pc_in[1:0] != 2'b00);
  assign w_redirect    = (r_state != c_IFB_S_IDLE) && (w_pc_word != r_head_addr);
  assign w_accept      = mem_req_valid && mem_req_ready;
  // Responses with nothing outstanding are stale (e.g. from before reset).
  assign w_rsp         = mem_rsp_valid && (r_outst != '0);
  assign w_drop        = w_rsp && (r_discard != '0);
  assign w_push        = w_rsp && !w_drop && !w_redirect && (!w_fifo_full || w_pop);
  assign w_pop         = instr_valid && instr_ack;
  // Buffered plus in-flight words never exceed the FIFO capacity.
  assign w_room        = ({1'b0, w_fifo_count} + {1'b0, r_outst}) < c_depth_ext;
  assign w_outst_nxt   = r_outst + c_cnt_w'(w_accept) - c_cnt_w'(w_rsp);
  // On redirect every word still in flight after this cycle becomes stale.
  assign w_discard_nxt = w_redirect ? w_outst_nxt :
                         w_drop     ? r_discard - c_cnt_w'(1) : r_discard;
  assign mem_req_addr  = r_fetch_addr;

  ifb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (w_redirect),
    .push  (w_push),
    .pop   (w_pop),
    .din   (mem_rsp_data),
    .dout  (w_fifo_head),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IFB_S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IFB_S_IDLE:  w_state_nxt = c_IFB_S_FETCH;
      c_IFB_S_FETCH: if (w_redirect && (w_outst_nxt != '0)) w_state_nxt = c_IFB_S_DRAIN;
      c_IFB_S_DRAIN: if (w_discard_nxt == '0) w_state_nxt = c_IFB_S_FETCH;
      default:       w_state_nxt = c_IFB_S_IDLE;
    endcase
  end

  // FSM outputs: request issue and core-facing instruction.
  always_comb begin
    mem_req_valid = (r_state == c_IFB_S_FETCH) && !w_redirect && w_room &&
                    (r_outst < c_max_outst);
    instr_valid   = (r_state == c_IFB_S_FETCH) && !w_fifo_empty &&
                    (r_head_addr == w_pc_word);
    instr_out     = instr_valid ? w_fifo_head : '0;
  end

  // Fetch/head address tracking; both reload from the PC on start or redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_addr <= '0;
      r_head_addr  <= '0;
    end else if ((r_state == c_IFB_S_IDLE) || w_redirect) begin
      r_fetch_addr <= w_pc_word;
      r_head_addr  <= w_pc_word;
    end else begin
      if (w_accept) r_fetch_addr <= r_fetch_addr + ADDR_W'(4);
      if (w_pop)    r_head_addr  <= r_head_addr + ADDR_W'(4);
    end
  end

  // In-flight and stale-response counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outst   <= '0;
      r_discard <= '0;
    end else begin
      r_outst   <= w_outst_nxt;
      r_discard <= w_discard_nxt;
    end
  end

`ifdef IFB_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched      <= '0;
      stat_flushes      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (w_push)     stat_fetched <= sat_inc32(stat_fetched);
      if (w_redirect) stat_flushes <= sat_inc32(stat_flushes);
      if ((r_state == c_IFB_S_FETCH) && !instr_valid)
        stat_stall_cycles <= sat_inc32(stat_stall_cycles);
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
// ============================================================================
// Module      : tb_instr_fetch_buffer
// Description : Self-checking bench for instr_fetch_buffer with a memory
//               model of programmable latency/ready and a core model that
//               advances the PC on every consumed instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_buffer;
  import instr_fetch_buffer_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = '0;
  logic        instr_ack = 1'b0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        pc_misaligned;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_consumed = 0;
  int          n_accepts = 0;
  int          first_rsp_cyc = -1;
  int          first_valid_cyc = -1;
  int          base;
  logic        saw_drain = 1'b0;
  logic        saw_zero_req = 1'b0;
  logic [31:0] exp_req_addr = '0;
  logic [31:0] exp_q [$];
  pend_t       pend_q [$];

  instr_fetch_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .instr_ack     (instr_ack),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .pc_misaligned (pc_misaligned),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // New fetch target: all pending expectations are void.
  task automatic set_pc(input logic [31:0] v);
    pc_in = v;
    exp_q.delete();
    exp_q.push_back(mem_word(align(v)));
    exp_req_addr = align(v);
  endtask

  // One clock: check/observe at negedge, update models just after posedge.
  task automatic step();
    logic        consumed;
    logic [31:0] e;
    pend_t       p;
    @(negedge clk);
    consumed = 1'b0;
    check_eq("pc_misaligned", {31'd0, pc_misaligned}, {31'd0, pc_in[1:0] != 2'b00});
    if (!instr_valid) check_eq("out_zero", instr_out, 32'd0);
    if (dut.r_state == c_IFB_S_DRAIN) saw_drain = 1'b1;
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (instr_valid && instr_ack) begin
      if (exp_q.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check_eq("instr", instr_out, e);
      end
      consumed = 1'b1;
      n_consumed++;
    end
    if (mem_rsp_valid) begin
      void'(pend_q.pop_front());
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
    end
    if (mem_req_valid && mem_req_ready) begin
      check_eq("req_addr", mem_req_addr, exp_req_addr);
      if (mem_req_addr == 32'd0) saw_zero_req = 1'b1;
      exp_req_addr = exp_req_addr + 32'd4;
      p.addr = mem_req_addr;
      p.due  = cyc + lat;
      pend_q.push_back(p);
      n_accepts++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (consumed) begin
      pc_in = pc_in + 32'd4;
      exp_q.push_back(mem_word(align(pc_in)));
    end
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(pend_q[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic run_consume(input int n, input int budget);
    int target;
    int k;
    target = n_consumed + n;
    k = 0;
    while (n_consumed < target && k < budget) begin
      step();
      k++;
    end
    if (n_consumed < target) check_eq("consume_timeout", n_consumed, target);
  endtask

  // Asynchronous reset applied mid-cycle, then one IDLE cycle.
  task automatic apply_reset(input logic [31:0] pc);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr_out", instr_out, 32'd0);
    check_eq("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    pend_q.delete();
    mem_rsp_valid = 1'b0;
    instr_ack = 1'b0;
    first_rsp_cyc = -1;
    first_valid_cyc = -1;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    reset = 1'b0;
    set_pc(pc);
    @(negedge clk);
    check_eq("idle_no_req", {31'd0, mem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // 1: streaming with 1-cycle memory
    apply_reset(32'd0);
    lat = 1;
    mem_req_ready = 1'b1;
    instr_ack = 1'b1;
    run_consume(8, 100);
    check_eq("valid_latency", first_valid_cyc - first_rsp_cyc, 32'd1);

    // 2: memory not ready holds the request stable
    apply_reset(32'd0);
    mem_req_ready = 1'b0;
    instr_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("hold_valid", {31'd0, mem_req_valid}, 32'd1);
      check_eq("hold_addr", mem_req_addr, 32'd0);
      check_eq("hold_no_instr", {31'd0, instr_valid}, 32'd0);
    end
    mem_req_ready = 1'b1;
    run_consume(1, 20);

    // 3: stalled core fills exactly DEPTH words; one ack frees one slot
    apply_reset(32'h200);
    base = n_accepts;
    for (int i = 0; i < 20; i++) step();
    check_eq("fill_accepts", n_accepts - base, 32'd4);
    check_eq("full_no_req", {31'd0, mem_req_valid}, 32'd0);
    instr_ack = 1'b1;
    run_consume(1, 10);
    instr_ack = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_eq("refill_accepts", n_accepts - base, 32'd5);

    // 4: jump with two requests in flight
    apply_reset(32'h8);
    lat = 3;
    for (int i = 0; i < 20 && pend_q.size() < 2; i++) step();
    check_eq("two_in_flight", pend_q.size(), 32'd2);
    saw_drain = 1'b0;
    set_pc(32'h100);
    instr_ack = 1'b1;
    run_consume(3, 60);
    check_eq("saw_drain", {31'd0, saw_drain}, 32'd1);

    // 5: redirect in the same cycle as a response
    apply_reset(32'd0);
    lat = 2;
    for (int i = 0; i < 20 && !mem_rsp_valid; i++) step();
    check_eq("rsp_seen", {31'd0, mem_rsp_valid}, 32'd1);
    set_pc(32'h300);
    instr_ack = 1'b1;
    run_consume(2, 40);
    lat = 1;
    for (int i = 0; i < 3; i++) step();

    // 6: reset mid-fetch, misaligned PC and address wrap
    apply_reset(32'h102);
    check_eq("misaligned_flag", {31'd0, pc_misaligned}, 32'd1);
    instr_ack = 1'b1;
    run_consume(2, 40);
    saw_zero_req = 1'b0;
    set_pc(32'hFFFF_FFFC);
    run_consume(2, 40);
    check_eq("wrap_req_zero", {31'd0, saw_zero_req}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
